keccak_pad_block: RTL

- Parametrised Keccak/SHA-3 input padder.
- Packs a word-serial message into RATE-bit blocks and applies multi-rate padding: a domain-separation byte after the last data byte, then 0x80 OR'd into the last byte of the block.
- Sits between the user input interface and the f_permutation core. Hands over one block at a time with a valid/ack handshake.
- Supports multi-block messages and back-to-back messages without reset.

---
 rtl/keccak_pad_block.sv | 102 ++++++++++
 1 files changed

// File: rtl/keccak_pad_block.sv
// Keccak/SHA-3 multi-rate padder: packs word-serial input into RATE-bit blocks,
// inserts the domain-separation byte after the last data byte and sets the final pad bit.
module keccak_pad_block #(
   parameter int unsigned RATE   = 576,
   parameter int unsigned W      = 64,
   parameter logic [7:0]  DSBYTE = 8'h06
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [W-1:0]              in,
   input  logic                      in_valid,
   input  logic                      is_last,
   input  logic [$clog2(W/8)-1:0]    byte_num,
   output logic                      in_ready,
   output logic [RATE-1:0]           out,
   output logic                      out_valid,
   output logic                      out_last,
   input  logic                      f_ack
);

   localparam int unsigned NW  = RATE / W;
   localparam int unsigned NB  = W / 8;
   localparam int unsigned BW  = $clog2(NB);
   localparam int unsigned WCW = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic [0:0] {StFill, StFull} state_e;

   state_e          state_q;
   logic [WCW-1:0]  wc_q;
   logic [RATE-1:0] out_q;
   logic [RATE-1:0] blk_d;
   logic            out_valid_q;
   logic            out_last_q;
   logic            in_ready_q;
   logic [W-1:0]    last_word;
   logic [W-1:0]    slot_word;

   // Later slots need no writes: the buffer is already zero at every block start.
   always_comb begin
      last_word = '0;
      for (int b = 0; b < NB; b++) begin
         if (BW'(b) < byte_num) begin
            last_word[W-1-8*b -: 8] = in[W-1-8*b -: 8];
         end else if (BW'(b) == byte_num) begin
            last_word[W-1-8*b -: 8] = DSBYTE;
         end
      end
      slot_word = is_last ? last_word : in;
      blk_d = out_q;
      for (int s = 0; s < NW; s++) begin
         if (wc_q == WCW'(s)) begin
            blk_d[RATE-1-s*W -: W] = slot_word;
         end
      end
      if (is_last) begin
         blk_d[7:0] = blk_d[7:0] | 8'h80;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StFill;
         wc_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state_q)
            StFill: begin
               if (in_valid) begin
                  out_q <= blk_d;
                  if (is_last || (wc_q == WCW'(NW - 1))) begin
                     state_q     <= StFull;
                     out_valid_q <= 1'b1;
                     out_last_q  <= is_last;
                     in_ready_q  <= 1'b0;
                     wc_q        <= '0;
                  end else begin
                     wc_q <= wc_q + 1'b1;
                  end
               end
            end
            StFull: begin
               if (f_ack) begin
                  state_q     <= StFill;
                  out_q       <= '0;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

endmodule
